// File: rtl/div_unit_if.sv
// Divider issue/writeback bundle: issue channel from execute, writeback channel
// toward the register-file write mux, plus hazard and FSM debug taps.
interface div_unit_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   // Both channels: a transfer happens on a rising edge where valid and ready are
   // both high; valid never waits on ready, and payload is stable while valid is high.
   logic                  start_valid;
   logic                  start_ready;
   logic [1:0]            op;
   logic [DATA_WIDTH-1:0] rs1_val;
   logic [DATA_WIDTH-1:0] rs2_val;
   logic [ADDR_WIDTH-1:0] rd;
   logic                  flush;
   logic                  busy;
   logic [ADDR_WIDTH-1:0] busy_rd;
   logic                  wb_valid;
   logic                  wb_ready;
   logic [ADDR_WIDTH-1:0] wb_rd;
   logic [DATA_WIDTH-1:0] wb_data;
   logic [1:0]            dbg_state;

   modport master (
      output start_valid, op, rs1_val, rs2_val, rd, flush, wb_ready,
      input  start_ready, busy, busy_rd, wb_valid, wb_rd, wb_data, dbg_state
   );

   modport slave (
      input  start_valid, op, rs1_val, rs2_val, rd, flush, wb_ready,
      output start_ready, busy, busy_rd, wb_valid, wb_rd, wb_data, dbg_state
   );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring RV32M divider (DIV/DIVU/REM/REMU), one op at a time.
// Optional macro DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow finish at accept.
module div_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input logic       clk,
   input logic       rst_n,
   div_unit_if.slave io
);
   localparam int CW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] LAST_STEP = CW'(DATA_WIDTH - 1);
   localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e                state_q;
   logic [1:0]            op_q;
   logic [ADDR_WIDTH-1:0] rd_q;
   logic [DATA_WIDTH-1:0] dvsr_q;
   logic [DATA_WIDTH-1:0] rem_q;
   logic [DATA_WIDTH-1:0] quo_q;
   logic [CW-1:0]         cnt_q;
   logic                  qsign_q;
   logic                  rsign_q;
   logic [ADDR_WIDTH-1:0] wb_rd_q;
   logic [DATA_WIDTH-1:0] wb_data_q;

   // Operand conditioning at accept
   logic                  a_neg, b_neg;
   logic [DATA_WIDTH-1:0] abs_a, abs_b;

   always_comb begin
      a_neg = 1'b0;
      b_neg = 1'b0;
      abs_a = io.rs1_val;
      abs_b = io.rs2_val;
      if (!io.op[0]) begin
         a_neg = io.rs1_val[DATA_WIDTH-1];
         b_neg = io.rs2_val[DATA_WIDTH-1];
         if (a_neg) abs_a = -io.rs1_val;
         if (b_neg) abs_b = -io.rs2_val;
      end
   end

`ifdef DIV_FAST_SPECIAL_EN
   logic                  sp_div0, sp_ovf, sp_hit;
   logic [DATA_WIDTH-1:0] sp_res;

   always_comb begin
      sp_div0 = (io.rs2_val == '0);
      sp_ovf  = !io.op[0] && (io.rs1_val == MIN_NEG) && (io.rs2_val == '1);
      sp_hit  = sp_div0 || sp_ovf;
      sp_res  = '0;
      if (sp_div0)     sp_res = io.op[1] ? io.rs1_val : '1;
      else if (sp_ovf) sp_res = io.op[1] ? '0 : MIN_NEG;
   end
`endif

   // One restoring step; rem < divisor always, so the shifted value fits in DATA_WIDTH+1 bits
   logic [DATA_WIDTH:0]   rem_sh, diff;
   logic [DATA_WIDTH-1:0] rem_nx, quo_nx, quo_fix, rem_fix, result;
   logic                  is_signed;

   always_comb begin
      rem_sh    = {rem_q, quo_q[DATA_WIDTH-1]};
      diff      = rem_sh - {1'b0, dvsr_q};
      rem_nx    = rem_sh[DATA_WIDTH-1:0];
      quo_nx    = {quo_q[DATA_WIDTH-2:0], 1'b0};
      if (!diff[DATA_WIDTH]) begin
         rem_nx = diff[DATA_WIDTH-1:0];
         quo_nx = {quo_q[DATA_WIDTH-2:0], 1'b1};
      end
      is_signed = !op_q[0];
      // A zero divisor leaves the all-ones quotient unsigned-looking, as RV32M requires
      quo_fix   = (is_signed && qsign_q && (dvsr_q != '0)) ? -quo_nx : quo_nx;
      rem_fix   = (is_signed && rsign_q) ? -rem_nx : rem_nx;
      result    = op_q[1] ? rem_fix : quo_fix;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         rd_q      <= '0;
         dvsr_q    <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         cnt_q     <= '0;
         qsign_q   <= 1'b0;
         rsign_q   <= 1'b0;
         wb_rd_q   <= '0;
         wb_data_q <= '0;
      end else if (io.flush) begin
         state_q <= S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (io.start_valid) begin
                  op_q    <= io.op;
                  rd_q    <= io.rd;
                  dvsr_q  <= abs_b;
                  quo_q   <= abs_a;
                  rem_q   <= '0;
                  qsign_q <= a_neg ^ b_neg;
                  rsign_q <= a_neg;
                  cnt_q   <= '0;
                  state_q <= S_CALC;
`ifdef DIV_FAST_SPECIAL_EN
                  if (sp_hit) begin
                     wb_data_q <= sp_res;
                     wb_rd_q   <= io.rd;
                     state_q   <= S_DONE;
                  end
`endif
               end
            end
            S_CALC: begin
               rem_q <= rem_nx;
               quo_q <= quo_nx;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST_STEP) begin
                  wb_data_q <= result;
                  wb_rd_q   <= rd_q;
                  state_q   <= S_DONE;
               end
            end
            S_DONE: begin
               if (io.wb_ready) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign io.start_ready = (state_q == S_IDLE);
   assign io.busy        = (state_q != S_IDLE);
   assign io.busy_rd     = rd_q;
   assign io.wb_valid    = (state_q == S_DONE);
   assign io.wb_rd       = wb_rd_q;
   assign io.wb_data     = wb_data_q;
   assign io.dbg_state   = state_q;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed RV32M cases, handshake stalls,
// flush/reset aborts, then random operations against an arithmetic model.
module tb_div_unit;
   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [31:0] exp_q[$];

   div_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dif ();

   div_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (dif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      longint sa, sb, r;
      sa = $signed(a);
      sb = $signed(b);
      r  = 0;
      case (op)
         2'b00: if (b == 0) r = -1; else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = sa;
                else r = sa / sb;
         2'b01: if (b == 0) r = 64'hFFFF_FFFF; else r = longint'(a) / longint'(b);
         2'b10: if (b == 0) r = sa; else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
                else r = sa % sb;
         default: if (b == 0) r = longint'(a); else r = longint'(a) % longint'(b);
      endcase
      return r[31:0];
   endfunction

   function automatic int exp_latency(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
`ifdef DIV_FAST_SPECIAL_EN
      if (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 0;
`endif
      return 32;
   endfunction

   // Caller is positioned at a negedge; returns positioned at the negedge after the handshake.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int hold);
      int lat;
      logic [31:0] exp;
      exp_q.push_back(ref_div(op, a, b));
      check("start_ready_idle", 32'(dif.start_ready), 32'd1);
      dif.start_valid = 1'b1;
      dif.op          = op;
      dif.rs1_val     = a;
      dif.rs2_val     = b;
      dif.rd          = rd;
      @(negedge clk);
      dif.start_valid = 1'b0;
      dif.rs1_val     = $urandom;
      dif.rs2_val     = $urandom;
      check("busy_after_accept", 32'(dif.busy), 32'd1);
      check("busy_rd", 32'(dif.busy_rd), 32'(rd));
      lat = 0;
      while (!dif.wb_valid && lat < 100) begin
         if (lat > 0 && dif.start_ready !== 1'b0) check("start_ready_calc", 32'(dif.start_ready), 32'd0);
         @(negedge clk);
         lat++;
      end
      check("latency", 32'(lat), 32'(exp_latency(op, a, b)));
      exp = exp_q.pop_front();
      check("wb_data", dif.wb_data, exp);
      check("wb_rd", 32'(dif.wb_rd), 32'(rd));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_wb_valid", 32'(dif.wb_valid), 32'd1);
         check("hold_wb_data", dif.wb_data, exp);
         check("hold_start_ready", 32'(dif.start_ready), 32'd0);
      end
      dif.wb_ready = 1'b1;
      @(negedge clk);
      dif.wb_ready = 1'b0;
      check("post_hs_wb_valid", 32'(dif.wb_valid), 32'd0);
      check("post_hs_busy", 32'(dif.busy), 32'd0);
      check("post_hs_busy_rd", 32'(dif.busy_rd), 32'(rd));
   endtask

   initial begin
      int seen_valid;
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      rst_n           = 1'b0;
      dif.start_valid = 1'b0;
      dif.op          = 2'b00;
      dif.rs1_val     = '0;
      dif.rs2_val     = '0;
      dif.rd          = '0;
      dif.flush       = 1'b0;
      dif.wb_ready    = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_start_ready", 32'(dif.start_ready), 32'd1);
      check("rst_busy", 32'(dif.busy), 32'd0);
      check("rst_busy_rd", 32'(dif.busy_rd), 32'd0);
      check("rst_wb_valid", 32'(dif.wb_valid), 32'd0);
      check("rst_wb_rd", 32'(dif.wb_rd), 32'd0);
      check("rst_wb_data", dif.wb_data, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(2'b01, 32'd100, 32'd7, 5'd5, 0);
      run_op(2'b11, 32'd100, 32'd7, 5'd6, 0);
      run_op(2'b00, 32'hFFFF_FFEC, 32'd3, 5'd7, 0);
      run_op(2'b10, 32'hFFFF_FFEC, 32'd3, 5'd8, 0);
      run_op(2'b00, 32'd20, 32'hFFFF_FFFD, 5'd9, 0);
      run_op(2'b00, 32'hFFFF_FFF9, 32'd0, 5'd10, 5);
      run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 5'd11, 0);
      run_op(2'b01, 32'h1234_5678, 32'd0, 5'd12, 0);
      run_op(2'b11, 32'h1234_5678, 32'd0, 5'd13, 0);
      run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 0);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 0);
      run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 5'd0, 2);

      // flush at CALC step 10
      dif.start_valid = 1'b1;
      dif.op = 2'b01; dif.rs1_val = 32'd1000; dif.rs2_val = 32'd3; dif.rd = 5'd20;
      @(negedge clk);
      dif.start_valid = 1'b0;
      repeat (10) @(negedge clk);
      dif.flush = 1'b1;
      @(negedge clk);
      dif.flush = 1'b0;
      check("flush_busy", 32'(dif.busy), 32'd0);
      check("flush_start_ready", 32'(dif.start_ready), 32'd1);
      seen_valid = 0;
      for (int i = 0; i < 40; i++) begin
         if (dif.wb_valid) seen_valid++;
         @(negedge clk);
      end
      check("flush_no_wb", 32'(seen_valid), 32'd0);

      // flush together with start_valid in IDLE
      dif.start_valid = 1'b1;
      dif.flush = 1'b1;
      @(negedge clk);
      dif.start_valid = 1'b0;
      dif.flush = 1'b0;
      check("flush_start_busy", 32'(dif.busy), 32'd0);
      check("flush_start_ready", 32'(dif.start_ready), 32'd1);

      // asynchronous reset mid-CALC
      dif.start_valid = 1'b1;
      dif.op = 2'b00; dif.rs1_val = 32'd77; dif.rs2_val = 32'd5; dif.rd = 5'd21;
      @(negedge clk);
      dif.start_valid = 1'b0;
      repeat (12) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("arst_start_ready", 32'(dif.start_ready), 32'd1);
      check("arst_busy", 32'(dif.busy), 32'd0);
      check("arst_busy_rd", 32'(dif.busy_rd), 32'd0);
      check("arst_wb_valid", 32'(dif.wb_valid), 32'd0);
      check("arst_wb_rd", 32'(dif.wb_rd), 32'd0);
      check("arst_wb_data", dif.wb_data, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int n = 0; n < 30; n++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 5))
            0: rb = 32'd0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = 32'($urandom_range(1, 20));
            3: rb = -32'($urandom_range(1, 20));
            default: ;
         endcase
         run_op(rop, ra, rb, 5'($urandom_range(0, 31)), $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
